// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode decoupling FIFO holding {PC, instruction} pairs; flush drops wrong-path entries.
// Latency: 1 cycle fetch-to-decode (no bypass); head is a combinational read of storage[rd_ptr].
// Backpressure: enablePC drops while full; a full queue refuses pushes even when popping that cycle.
// Ports: clk, reset (async active-low); fetch_valid/fetch_pc/fetch_instr in, enablePC out;
//        flush in; dec_valid/dec_pc/dec_instr out with dec_ready in; occupancy, overflow_err out.
module fetch_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_valid,
  input  logic [PC_W-1:0]    fetch_pc,
  input  logic [INSTR_W-1:0] fetch_instr,
  output logic               enablePC,
  input  logic               flush,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [PC_W-1:0]    dec_pc,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [CNT_W-1:0]   occupancy,
  output logic               overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status derives from the registered count only, so enablePC never
  // depends combinationally on dec_ready or flush.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign enablePC  = !full;
  assign dec_valid = !empty;
  assign dec_pc    = pc_mem[rd_ptr];
  assign dec_instr = instr_mem[rd_ptr];
  assign occupancy = count;

  // Flush kills both sides: the fetch beat that cycle is wrong-path and the
  // head is being discarded anyway.
  assign push = fetch_valid & !full & !flush;
  assign pop  = dec_valid & dec_ready & !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      if (fetch_valid && full && !flush) begin
        overflow_err <= 1'b1;
      end

      if (flush) begin
        // Storage left stale; with count at zero it is never presented.
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]    <= fetch_pc;
          instr_mem[wr_ptr] <= fetch_instr;
          wr_ptr            <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed stimulus, scoreboard of expected head
// entries consumed by a negedge monitor, plus directed status checks.
module tb_fetch_decode_queue;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               fetch_valid = 1'b0;
  logic [PC_W-1:0]    fetch_pc = '0;
  logic [INSTR_W-1:0] fetch_instr = '0;
  logic               flush = 1'b0;
  logic               dec_ready = 1'b0;
  logic               enablePC;
  logic               dec_valid;
  logic [PC_W-1:0]    dec_pc;
  logic [INSTR_W-1:0] dec_instr;
  logic [CNT_W-1:0]   occupancy;
  logic               overflow_err;

  int total = 0;
  int bad   = 0;

  // Expected entries in decode order: {pc, instr}.
  logic [PC_W+INSTR_W-1:0] sb [$];

  fetch_decode_queue #(
    .DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .enablePC(enablePC), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return 32'hA000_0000 + 32'(pc >> 2);
  endfunction

  // Drive one cycle of inputs; acc says whether the queue is expected to accept it.
  task automatic issue(input bit v, input logic [PC_W-1:0] pc, input bit rdy,
                       input bit fl, input bit acc);
    fetch_valid = v;
    fetch_pc    = pc;
    fetch_instr = instr_of(pc);
    dec_ready   = rdy;
    flush       = fl;
    if (fl) sb.delete();
    if (acc) sb.push_back({pc, instr_of(pc)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever decode sees a valid head, it must be the oldest expected
  // entry; consumed when dec_ready is high. Also catches head instability.
  always @(negedge clk) begin
    if (reset && !flush && dec_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL head_unexpected: dec_pc=0x%0h with nothing expected", dec_pc);
      end else begin
        chk("head_pc", dec_pc, sb[0][PC_W+INSTR_W-1:INSTR_W]);
        chk("head_instr", 64'(dec_instr), 64'(sb[0][INSTR_W-1:0]));
        if (dec_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_enablePC", 64'(enablePC), 64'd1);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk("rst_dec_pc", dec_pc, 64'd0);
    chk("rst_dec_instr", 64'(dec_instr), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // T1: three pushes, decode stalled; head stays at PC 0
    for (int i = 0; i < 3; i++) begin
      issue(1, 64'(i * 4), 0, 0, 1);
      step();
      chk("t1_occupancy", 64'(occupancy), 64'(i + 1));
      chk("t1_dec_valid", 64'(dec_valid), 64'd1);
      chk("t1_dec_pc", dec_pc, 64'd0);
    end

    // T2: fill, then one push attempt while full
    issue(1, 64'h0C, 0, 0, 1);
    step();
    chk("t2_occupancy_full", 64'(occupancy), 64'd4);
    chk("t2_enablePC_full", 64'(enablePC), 64'd0);
    chk("t2_overflow_pre", 64'(overflow_err), 64'd0);
    issue(1, 64'h10, 0, 0, 0);
    step();
    chk("t2_occupancy_hold", 64'(occupancy), 64'd4);
    chk("t2_overflow_set", 64'(overflow_err), 64'd1);
    chk("t2_dec_pc_hold", dec_pc, 64'd0);

    // T3: full with pop and push on same edge -> pop only
    issue(1, 64'h14, 1, 0, 0);
    step();
    chk("t3_occupancy", 64'(occupancy), 64'd3);
    chk("t3_enablePC", 64'(enablePC), 64'd1);
    chk("t3_dec_pc", dec_pc, 64'h04);
    // drain
    for (int i = 0; i < 3; i++) begin
      issue(0, 64'h0, 1, 0, 0);
      step();
    end
    chk("t3_drained", 64'(occupancy), 64'd0);
    chk("t3_drained_valid", 64'(dec_valid), 64'd0);
    chk("t3_overflow_sticky", 64'(overflow_err), 64'd1);

    // T4: streaming push+pop, PCs 0x0..0x24; dec_ready while empty is ignored
    for (int i = 0; i < 10; i++) begin
      issue(1, 64'(i * 4), 1, 0, 1);
      step();
      chk("t4_occupancy", 64'(occupancy), 64'd1);
      chk("t4_dec_pc", dec_pc, 64'(i * 4));
    end
    issue(0, 64'h0, 1, 0, 0);
    step();
    chk("t4_drained", 64'(occupancy), 64'd0);

    // T5: flush with a wrong-path fetch beat
    for (int i = 0; i < 3; i++) begin
      issue(1, 64'h40 + 64'(i * 4), 0, 0, 1);
      step();
    end
    chk("t5_occupancy_pre", 64'(occupancy), 64'd3);
    issue(1, 64'h100, 0, 1, 0);
    chk("t5_enablePC_during_flush", 64'(enablePC), 64'd1);
    step();
    chk("t5_dec_valid", 64'(dec_valid), 64'd0);
    chk("t5_occupancy", 64'(occupancy), 64'd0);
    issue(1, 64'h200, 0, 0, 1);
    step();
    chk("t5_new_valid", 64'(dec_valid), 64'd1);
    chk("t5_new_pc", dec_pc, 64'h200);
    chk("t5_new_instr", 64'(dec_instr), 64'(instr_of(64'h200)));
    chk("t5_occupancy_new", 64'(occupancy), 64'd1);
    issue(0, 64'h0, 1, 0, 0);
    step();
    chk("t5_drained", 64'(occupancy), 64'd0);

    // T6: asynchronous reset mid-cycle with two entries queued
    for (int i = 0; i < 2; i++) begin
      issue(1, 64'h300 + 64'(i * 4), 0, 0, 1);
      step();
    end
    issue(0, 64'h0, 0, 0, 0);
    chk("t6_occupancy_pre", 64'(occupancy), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    chk("t6_dec_valid", 64'(dec_valid), 64'd0);
    chk("t6_occupancy", 64'(occupancy), 64'd0);
    chk("t6_overflow", 64'(overflow_err), 64'd0);
    chk("t6_dec_pc", dec_pc, 64'd0);
    chk("t6_enablePC", 64'(enablePC), 64'd1);
    step();
    #2;
    reset = 1'b1;
    step();
    chk("t6_post_valid", 64'(dec_valid), 64'd0);
    chk("t6_post_occupancy", 64'(occupancy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Decoupling FIFO directly downstream of the instruction fetch stage, upstream of decode.
- Captures each fetched {PC, instruction} pair and presents it to decode with a valid/ready handshake.
- Back-pressures fetch by dropping the PC enable when full.
- Discards all wrong-path entries on a branch/BR redirect flush.

Parameters:
DEPTH, 4, number of entries; power of 2, >= 2
PC_W, 64, PC/address width
INSTR_W, 32, instruction width
CNT_W, $clog2(DEPTH)+1, occupancy width

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low; 0 = in reset
fetch_valid  input  1  fetch presents an instruction this cycle
fetch_pc  input  PC_W  address of presented instruction
fetch_instr  input  INSTR_W  presented instruction word
enablePC  output  1  PC-register enable to fetch; 1 = queue can accept
flush  input  1  redirect (brTaken/BRMI resolved taken); discard all contents
dec_valid  output  1  head entry valid
dec_ready  input  1  decode consumes head this cycle
dec_pc  output  PC_W  PC of head entry
dec_instr  output  INSTR_W  instruction of head entry
occupancy  output  CNT_W  number of valid entries, 0..DEPTH
overflow_err  output  1  sticky: push attempted while full

Behaviour:
- Storage: DEPTH x (PC_W+INSTR_W) register array; wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH); count (CNT_W bits).
- Reset (reset=0, asynchronous): wr_ptr=rd_ptr=count=0; overflow_err=0; all storage=0. Outputs: dec_valid=0, dec_pc=0, dec_instr=0, occupancy=0, enablePC=1.
- full = (count==DEPTH); empty = (count==0); both from registered count only.
- enablePC = !full (combinational).
- dec_valid = !empty.
- dec_pc and dec_instr = storage[rd_ptr] (combinational read of head).
- occupancy = count.
- push = fetch_valid & !full & !flush.
  - On push: storage[wr_ptr] <= {fetch_pc, fetch_instr}; wr_ptr++.
- pop = dec_valid & dec_ready & !flush.
  - On pop: rd_ptr++.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- When full, push is refused even if pop occurs in the same cycle; there is no same-cycle refill.
- No bypass: an entry pushed at edge N is visible on dec_valid/dec_pc/dec_instr after edge N. Fetch-to-decode latency is 1 cycle.
- dec_ready while empty: ignored, no state change.
- Flush (flush=1 at a rising edge): wr_ptr, rd_ptr, count <= 0.
  - Incoming fetch data that cycle is discarded as wrong-path.
  - No pop is performed.
  - Storage contents are left stale but unobservable.
  - overflow_err is unchanged.
  - dec_valid=0 from the next cycle.
  - enablePC is not gated by flush, so fetch loads the redirect target that edge.
- overflow_err: set to 1 at any edge where fetch_valid=1 and full=1 (flush=0); it stays set until reset.
- Reset asserted mid-operation: immediate clear of all state, independent of clk. Queue is empty after deassertion.
- Handshake stability: while dec_valid=1 and dec_ready=0, dec_pc/dec_instr must hold constant. Pushes never modify the head entry.

Test Plan:
1. Reset, then push PC 0x0,0x4,0x8 (instr 0xA0000000+i) with dec_ready=0 -> occupancy 1,2,3; dec_valid=1; dec_pc=0x0 held steady throughout.
2. Fill to 4 entries, then fetch_valid=1 one more cycle -> enablePC=0, occupancy stays 4, overflow_err=1 and remains 1 after draining.
3. Full queue with dec_ready=1 and fetch_valid=1 on the same edge -> one pop, no push, occupancy 3, enablePC=1 next cycle.
4. Continuous push+pop for 10 cycles with PCs 0x0..0x24 -> occupancy constant at 1; decode sees PCs in order with 1-cycle latency; pointers wrap past entry 3 correctly.
5. Three entries queued, flush=1 with fetch_valid=1 (PC 0x100) -> next cycle dec_valid=0, occupancy 0, 0x100 not stored. Next push of PC 0x200 appears as head one cycle later.
6. reset pulsed low asynchronously between clock edges with 2 entries queued -> dec_valid, occupancy, overflow_err and dec_pc all 0 immediately, before the next clk edge.
